// File: rtl/pdp8_operand_access_pkg.sv
// CPU_Definitions: shared types and constants for the PDP-8 memory-side logic.
//   word                  12-bit machine word
//   access_op_t           job requested of pdp8_operand_access
//   oa_state_t            sequencer states of pdp8_operand_access
//   DATA_READ /
//   INSTRUCTION_READ      encodings of memory_controller.read_type
//   is_auto_index()       true when an address lies in the auto-index window
package CPU_Definitions;

    typedef logic [11:0] word;

    typedef enum logic [1:0] {
        OP_FETCH   = 2'd0,
        OP_EA_ONLY = 2'd1,
        OP_READ    = 2'd2,
        OP_WRITE   = 2'd3
    } access_op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_IND_REQ   = 3'd1,
        ST_IND_WAIT  = 3'd2,
        ST_AUTO_REQ  = 3'd3,
        ST_AUTO_WAIT = 3'd4,
        ST_OP_REQ    = 3'd5,
        ST_OP_WAIT   = 3'd6,
        ST_DONE      = 3'd7
    } oa_state_t;

    localparam logic DATA_READ        = 1'b0;
    localparam logic INSTRUCTION_READ = 1'b1;

    // Page-zero locations 0010-0017 increment their contents when used indirectly.
    localparam word AUTO_LO_DEF = 12'o0010;
    localparam word AUTO_HI_DEF = 12'o0017;

    function automatic logic is_auto_index(input word w,
                                           input word lo = AUTO_LO_DEF,
                                           input word hi = AUTO_HI_DEF);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/memory_pins.sv
// memory_pins: single-access request/acknowledge bus between an initiator
// (master) and memory_controller (slave).
//   address, write_data        master -> slave, held for the whole access
//   read_enable, write_enable  master -> slave, one-cycle request strobe
//   read_data, mem_finished    slave -> master, data valid with mem_finished
interface memory_pins;
    logic [11:0] address;
    logic [11:0] write_data;
    logic        read_enable;
    logic        write_enable;
    logic [11:0] read_data;
    logic        mem_finished;

    modport master (
        output address, write_data, read_enable, write_enable,
        input  read_data, mem_finished
    );

    modport slave (
        input  address, write_data, read_enable, write_enable,
        output read_data, mem_finished
    );
endinterface

// File: rtl/pdp8_operand_access_bus.sv
// pdp8_bus_handshake: REQ/WAIT sequencing for one memory access.
//   clk, rst_n   clock, synchronous active-low reset
//   go           one-cycle request (REQ cycle); enable is driven in this cycle
//   is_write     selects write_enable instead of read_enable
//   addr, data   address and write data presented with go
//   ack          mem_finished seen while an access is outstanding
//   rdata        read_data from the slave, valid with ack
//   pins         master end of memory_pins
module pdp8_bus_handshake
    import CPU_Definitions::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       is_write,
    input  word        addr,
    input  word        data,
    output logic       ack,
    output word        rdata,
    memory_pins.master pins
);

    word  addr_q;
    word  data_q;
    logic pending_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
        end else if (go) begin
            addr_q    <= addr;
            if (is_write)
                data_q <= data;
            pending_q <= 1'b1;
        end else if (pending_q && pins.mem_finished) begin
            pending_q <= 1'b0;
        end
    end

    // The REQ cycle presents the new address directly; the captured copy
    // then holds it through WAIT without an extra cycle of latency.
    assign pins.address      = go ? addr : addr_q;
    assign pins.write_data   = (go && is_write) ? data : data_q;
    assign pins.read_enable  = go && !is_write;
    assign pins.write_enable = go && is_write;

    // A stray mem_finished with nothing outstanding never acknowledges.
    assign ack   = pending_q && pins.mem_finished;
    assign rdata = pins.read_data;

endmodule

// File: rtl/pdp8_operand_access.sv
// pdp8_operand_access: instruction fetch, effective-address formation
// (direct, indirect, auto-index) and optional operand access for the CPU.
//   clk, rst_n        clock, synchronous active-low reset
//   start             job request, accepted only while busy=0
//   op, instr, pc,
//   wdata             job description, captured with start
//   busy              high from the cycle after start through the done cycle
//   done              one-cycle completion pulse
//   ea                effective address (pc for a fetch)
//   rdata             fetched word or operand; 0 for EA_ONLY/WRITE
//   read_type         DATA_READ / INSTRUCTION_READ to memory_controller
//   pins              master end of memory_pins
module pdp8_operand_access
    import CPU_Definitions::*;
#(
    parameter word AUTO_LO = AUTO_LO_DEF,
    parameter word AUTO_HI = AUTO_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  access_op_t op,
    input  logic [11:0] instr,
    input  logic [11:0] pc,
    input  logic [11:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [11:0] ea,
    output logic [11:0] rdata,
    output logic       read_type,
    memory_pins.master pins
);

    oa_state_t  state, state_next;
    access_op_t op_q;
    word        base_q, ea_q, rdata_q, wdata_q;
    logic       busy_q, done_q, read_type_q;

    logic go, hs_write, ack;
    word  hs_addr, hs_data, hs_rdata;

    // Opcode bits do not affect addressing.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[11:9];

    // Z selects the current page, otherwise page zero.
    word base_in;
    assign base_in = instr[7] ? {pc[11:7], instr[6:0]} : {5'b0, instr[6:0]};

    logic accept, needs_op, auto_hit;
    word  ptr;
    assign accept   = (state == ST_IDLE) && start && !busy_q;
    assign needs_op = (op_q == OP_READ) || (op_q == OP_WRITE);
    assign auto_hit = is_auto_index(base_q, AUTO_LO, AUTO_HI);
    assign ptr      = auto_hit ? hs_rdata + 12'd1 : hs_rdata;

    pdp8_bus_handshake u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .is_write (hs_write),
        .addr     (hs_addr),
        .data     (hs_data),
        .ack      (ack),
        .rdata    (hs_rdata),
        .pins     (pins)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        go         = 1'b0;
        hs_write   = 1'b0;
        hs_addr    = ea_q;
        hs_data    = wdata_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_FETCH)                        state_next = ST_OP_REQ;
                    else if (instr[8])                         state_next = ST_IND_REQ;
                    else if (op == OP_READ || op == OP_WRITE)  state_next = ST_OP_REQ;
                    else                                       state_next = ST_DONE;
                end
            end
            ST_IND_REQ: begin
                go         = 1'b1;
                hs_addr    = base_q;
                state_next = ST_IND_WAIT;
            end
            ST_IND_WAIT: begin
                if (ack) begin
                    if (auto_hit)      state_next = ST_AUTO_REQ;
                    else if (needs_op) state_next = ST_OP_REQ;
                    else               state_next = ST_DONE;
                end
            end
            ST_AUTO_REQ: begin
                // ea_q already holds the incremented pointer.
                go         = 1'b1;
                hs_write   = 1'b1;
                hs_addr    = base_q;
                hs_data    = ea_q;
                state_next = ST_AUTO_WAIT;
            end
            ST_AUTO_WAIT: begin
                if (ack) state_next = needs_op ? ST_OP_REQ : ST_DONE;
            end
            ST_OP_REQ: begin
                go         = 1'b1;
                hs_write   = (op_q == OP_WRITE);
                state_next = ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
                if (ack) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_FETCH;
            base_q      <= '0;
            ea_q        <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_type_q <= DATA_READ;
        end else begin
            done_q <= (state == ST_DONE);
            // busy covers the done cycle, so a start coincident with done is ignored.
            if (done_q)
                busy_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy_q      <= 1'b1;
                        op_q        <= op;
                        wdata_q     <= wdata;
                        rdata_q     <= '0;
                        base_q      <= base_in;
                        ea_q        <= (op == OP_FETCH) ? pc : base_in;
                        read_type_q <= (op == OP_FETCH) ? INSTRUCTION_READ : DATA_READ;
                    end
                end
                ST_IND_WAIT: if (ack) ea_q <= ptr;
                ST_OP_WAIT:  if (ack && op_q != OP_WRITE) rdata_q <= hs_rdata;
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ea        = ea_q;
    assign rdata     = rdata_q;
    assign read_type = read_type_q;

endmodule
